// File: rtl/raster_window_streamer.sv
// raster_window_streamer: buffers KERNEL_SIZE raster rows and re-emits them in column-band order
module raster_window_streamer #(
    parameter int DATA_WIDTH  = 8,
    parameter int KERNEL_SIZE = 3,
    parameter int MAX_WIDTH   = 1024
) (
    input  logic                    axi_clk,
    input  logic                    axi_reset_n,
    input  logic [15:0]             cfg_width,
    input  logic [15:0]             cfg_height,
    input  logic                    cfg_start,
    output logic                    busy,
    output logic                    done,
    output logic                    cfg_error,
    output logic                    frame_error,
    input  logic                    s_axis_valid,
    input  logic [DATA_WIDTH-1:0]   s_axis_data,
    output logic                    s_axis_ready,
    input  logic                    s_axis_last,
    output logic                    m_axis_valid,
    output logic [DATA_WIDTH-1:0]   m_axis_data,
    input  logic                    m_axis_ready,
    output logic                    m_axis_last,
    output logic [DATA_WIDTH/8-1:0] m_axis_keep
);
    localparam int SW = KERNEL_SIZE > 1 ? $clog2(KERNEL_SIZE) : 1;
    localparam int CW = MAX_WIDTH > 1 ? $clog2(MAX_WIDTH) : 1;
    localparam logic [SW-1:0] K_LAST = SW'(KERNEL_SIZE - 1);
    localparam logic [SW:0] K_NUM = (SW + 1)'(KERNEL_SIZE);
    localparam logic [15:0] K16 = 16'(KERNEL_SIZE);
    localparam logic [15:0] MW16 = 16'(MAX_WIDTH);

    typedef enum logic [2:0] {IDLE, FILL, EMIT, LOAD, DONE} state_t;
    state_t state, state_nx;

    logic [DATA_WIDTH-1:0] line_ram [KERNEL_SIZE][MAX_WIDTH];
    logic [DATA_WIDTH-1:0] fifo_d [2];
    logic fifo_l [2];
    logic [15:0] w_last, h_last, band_last, wcol, in_row, rcol, band;
    logic [SW-1:0] wrow, top, rk, wslot, rslot;
    logic [SW:0] rsum;
    logic [1:0] cnt;
    logic wp, rp, iss_done;
    logic cfg_ok, acc, row_end, pop, issue, band_end, final_band, exp_last;

    assign cfg_ok = cfg_width >= K16 && cfg_width <= MW16 && cfg_height >= K16;
    assign acc = s_axis_valid && s_axis_ready;
    assign row_end = wcol == w_last;
    assign exp_last = row_end && in_row == h_last;
    assign pop = m_axis_valid && m_axis_ready;
    // a read is issued whenever the two-entry skid buffer will have room after this cycle's pop
    assign issue = state == EMIT && !iss_done && (cnt != 2'd2 || pop);
    assign band_end = rcol == w_last && rk == K_LAST;
    assign final_band = band == band_last;
    assign wslot = state == LOAD ? top : wrow;
    assign rsum = {1'b0, top} + {1'b0, rk};
    assign rslot = SW'(rsum >= K_NUM ? rsum - K_NUM : rsum);
    assign m_axis_valid = cnt != 2'd0;
    assign m_axis_data = m_axis_valid ? fifo_d[rp] : '0;
    assign m_axis_last = m_axis_valid && fifo_l[rp];
    assign m_axis_keep = {(DATA_WIDTH/8){m_axis_valid}};

    // state register
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) state <= IDLE;
        else state <= state_nx;
    end

    // next state: bands other than the last hand over to LOAD as soon as their reads are issued
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = cfg_start && cfg_ok ? FILL : IDLE;
            FILL: state_nx = acc && row_end && wrow == K_LAST ? EMIT : FILL;
            EMIT: state_nx = issue && band_end && !final_band ? LOAD :
                             iss_done && cnt == 2'd0 ? DONE : EMIT;
            LOAD: state_nx = acc && row_end ? EMIT : LOAD;
            DONE: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // state-decoded outputs
    always_comb begin
        busy = state == FILL || state == EMIT || state == LOAD;
        done = state == DONE;
        s_axis_ready = state == FILL || state == LOAD;
    end

    // config latch, error flags, write/read counters and skid-buffer occupancy
    always_ff @(posedge axi_clk or negedge axi_reset_n) begin
        if (!axi_reset_n) begin
            cfg_error <= 1'b0;
            frame_error <= 1'b0;
            w_last <= '0;
            h_last <= '0;
            band_last <= '0;
            wcol <= '0;
            in_row <= '0;
            rcol <= '0;
            band <= '0;
            wrow <= '0;
            top <= '0;
            rk <= '0;
            iss_done <= 1'b0;
            cnt <= '0;
            wp <= 1'b0;
            rp <= 1'b0;
        end else begin
            if (state == IDLE && cfg_start) begin
                cfg_error <= !cfg_ok;
                if (cfg_ok) begin
                    frame_error <= 1'b0;
                    w_last <= cfg_width - 16'd1;
                    h_last <= cfg_height - 16'd1;
                    band_last <= cfg_height - K16;
                    wcol <= '0;
                    in_row <= '0;
                    rcol <= '0;
                    band <= '0;
                    wrow <= '0;
                    top <= '0;
                    rk <= '0;
                    iss_done <= 1'b0;
                end
            end
            if (acc) begin
                wcol <= row_end ? '0 : wcol + 16'd1;
                if (row_end) in_row <= in_row + 16'd1;
                if (row_end) wrow <= wrow + 1'b1;
                if (s_axis_last != exp_last) frame_error <= 1'b1;
                if (state == LOAD && row_end) top <= top == K_LAST ? '0 : top + 1'b1;
            end
            if (issue) begin
                rk <= rk == K_LAST ? '0 : rk + 1'b1;
                if (rk == K_LAST) rcol <= rcol == w_last ? '0 : rcol + 16'd1;
                if (band_end) band <= band + 16'd1;
                if (band_end) iss_done <= final_band;
                wp <= ~wp;
            end
            if (pop) rp <= ~rp;
            cnt <= cnt + {1'b0, issue} - {1'b0, pop};
        end
    end

    // line RAM write and synchronous read straight into the skid buffer
    always_ff @(posedge axi_clk) begin
        if (acc) line_ram[wslot][wcol[CW-1:0]] <= s_axis_data;
        if (issue) fifo_d[wp] <= line_ram[rslot][rcol[CW-1:0]];
        if (issue) fifo_l[wp] <= band_end && final_band;
    end
endmodule

// File: tb/tb_raster_window_streamer.sv
// tb_raster_window_streamer: randomized scoreboard bench for raster_window_streamer
module tb_raster_window_streamer;
    localparam int DW = 8;
    localparam int K = 3;
    localparam int MW = 1024;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [15:0] cfg_width = '0;
    logic [15:0] cfg_height = '0;
    logic cfg_start = 1'b0;
    logic busy, done, cfg_error, frame_error;
    logic s_axis_valid = 1'b0;
    logic [DW-1:0] s_axis_data = '0;
    logic s_axis_ready;
    logic s_axis_last = 1'b0;
    logic m_axis_valid;
    logic [DW-1:0] m_axis_data;
    logic m_axis_ready = 1'b0;
    logic m_axis_last;
    logic [DW/8-1:0] m_axis_keep;

    raster_window_streamer #(.DATA_WIDTH(DW), .KERNEL_SIZE(K), .MAX_WIDTH(MW)) dut (
        .axi_clk(clk), .axi_reset_n(rst_n),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_start(cfg_start),
        .busy(busy), .done(done), .cfg_error(cfg_error), .frame_error(frame_error),
        .s_axis_valid(s_axis_valid), .s_axis_data(s_axis_data), .s_axis_ready(s_axis_ready),
        .s_axis_last(s_axis_last),
        .m_axis_valid(m_axis_valid), .m_axis_data(m_axis_data), .m_axis_ready(m_axis_ready),
        .m_axis_last(m_axis_last), .m_axis_keep(m_axis_keep)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [DW-1:0] d;
        logic l;
    } beat_t;

    beat_t exp_q[$];
    logic [DW-1:0] pix[$];
    int checks = 0;
    int failures = 0;
    int beats = 0;
    int acc_in = 0;
    int done_cnt = 0;
    int done_base = 0;
    int cur_w = 1;
    int cyc = 0;
    int first_cyc = 0;
    int band0_cyc = 0;
    bit rdy_rand = 0;
    bit feed_active = 0;
    bit abort = 0;
    bit prev_stall = 0;
    logic [DW-1:0] prev_d;
    logic prev_l;

    task automatic chk(input bit ok, input string name, input longint act, input longint exp);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // downstream ready: always 1 or a ~50% coin flip per cycle
    initial forever begin
        @(posedge clk);
        #1;
        m_axis_ready = rdy_rand ? 1'($urandom % 2) : 1'b1;
    end

    // monitor: pops the scoreboard on every transfer, checks holding under stall and input gating
    always @(negedge clk) begin
        beat_t e;
        logic [DW/8-1:0] kexp;
        int p;
        int b;
        cyc++;
        if (!rst_n) prev_stall = 0;
        else begin
            if (done) done_cnt++;
            if (s_axis_valid && s_axis_ready) acc_in++;
            if (prev_stall) begin
                chk(m_axis_valid == 1'b1, "stall_valid_held", m_axis_valid, 1);
                chk(m_axis_data == prev_d, "stall_data_held", m_axis_data, prev_d);
                chk(m_axis_last == prev_l, "stall_last_held", m_axis_last, prev_l);
            end
            kexp = m_axis_valid ? '1 : '0;
            chk(m_axis_keep == kexp, "keep", m_axis_keep, kexp);
            if (m_axis_valid && m_axis_ready) begin
                if (exp_q.size() == 0) chk(0, "unexpected_beat", beats, -1);
                else begin
                    e = exp_q.pop_front();
                    chk(m_axis_data == e.d, "beat_data", m_axis_data, e.d);
                    chk(m_axis_last == e.l, "beat_last", m_axis_last, e.l);
                end
                if (beats == 0) first_cyc = cyc;
                if (beats == cur_w * K - 1) band0_cyc = cyc;
                p = beats % (cur_w * K);
                b = beats / (cur_w * K);
                if (p < cur_w * K - 2) chk(acc_in == (K + b) * cur_w, "inputs_before_band", acc_in, (K + b) * cur_w);
                beats++;
            end
            prev_stall = m_axis_valid && !m_axis_ready;
            prev_d = m_axis_data;
            prev_l = m_axis_last;
        end
    end

    task automatic feed(input int w, input int h, input int err);
        int i = 0;
        bit a;
        feed_active = 1;
        while (i < w * h && !abort) begin
            s_axis_valid = ($urandom % 4) != 0;
            s_axis_data = pix[i];
            s_axis_last = (i == w * h - 1) || (i == err);
            @(negedge clk);
            a = s_axis_valid && s_axis_ready;
            @(posedge clk);
            #1;
            if (a) i++;
        end
        s_axis_valid = 0;
        s_axis_last = 0;
        feed_active = 0;
    endtask

    task automatic pulse_start(input int w, input int h);
        @(posedge clk);
        #1;
        cfg_width = 16'(w);
        cfg_height = 16'(h);
        cfg_start = 1;
        @(posedge clk);
        #1;
        cfg_start = 0;
    endtask

    // builds the frame, fills the scoreboard from the column-band rule, starts DUT and feeder
    task automatic start(input int w, input int h, input int err, input bit rnd_rdy, input bit rnd_pix);
        pix.delete();
        for (int i = 0; i < w * h; i++) pix.push_back(rnd_pix ? DW'($urandom) : DW'(i));
        exp_q.delete();
        for (int b = 0; b <= h - K; b++)
            for (int c = 0; c < w; c++)
                for (int k = 0; k < K; k++)
                    exp_q.push_back('{pix[(b + k) * w + c], (b == h - K) && (c == w - 1) && (k == K - 1)});
        beats = 0;
        acc_in = 0;
        cur_w = w;
        rdy_rand = rnd_rdy;
        abort = 0;
        done_base = done_cnt;
        pulse_start(w, h);
        chk(busy == 1'b1, "busy_after_start", busy, 1);
        chk(cfg_error == 1'b0, "cfg_error_clear", cfg_error, 0);
        fork
            feed(w, h, err);
        join_none
    endtask

    task automatic wait_done(input int w, input int h, input bit ferr);
        int t = 0;
        while (done_cnt == done_base && t < 20000) begin
            @(posedge clk);
            t++;
        end
        if (t >= 20000) abort = 1;
        chk(t < 20000, "done_timeout", t, 20000);
        repeat (3) @(posedge clk);
        #1;
        chk(done_cnt == done_base + 1, "done_once", done_cnt - done_base, 1);
        chk(beats == (h - K + 1) * w * K, "beat_count", beats, (h - K + 1) * w * K);
        chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
        chk(busy == 1'b0, "busy_after_done", busy, 0);
        chk(s_axis_ready == 1'b0, "s_ready_idle", s_axis_ready, 0);
        chk(frame_error == ferr, "frame_error", frame_error, ferr);
        chk(feed_active == 0, "input_consumed", feed_active, 0);
    endtask

    initial begin
        int t;
        int w;
        int h;
        repeat (3) @(posedge clk);
        #1;
        chk(busy == 0, "rst_busy", busy, 0);
        chk(done == 0, "rst_done", done, 0);
        chk(cfg_error == 0, "rst_cfg_error", cfg_error, 0);
        chk(frame_error == 0, "rst_frame_error", frame_error, 0);
        chk(s_axis_ready == 0, "rst_s_ready", s_axis_ready, 0);
        chk(m_axis_valid == 0, "rst_m_valid", m_axis_valid, 0);
        chk(m_axis_last == 0, "rst_m_last", m_axis_last, 0);
        rst_n = 1;

        start(5, 4, -1, 0, 0);
        wait_done(5, 4, 0);
        start(5, 4, -1, 1, 0);
        wait_done(5, 4, 0);
        start(25, 25, -1, 0, 0);
        wait_done(25, 25, 0);
        chk(band0_cyc - first_cyc == 25 * K - 1, "band0_throughput", band0_cyc - first_cyc, 25 * K - 1);

        pulse_start(2, 25);
        repeat (3) begin
            @(posedge clk);
            #1;
            chk(s_axis_ready == 0, "rejected_s_ready", s_axis_ready, 0);
        end
        chk(cfg_error == 1, "cfg_error_narrow", cfg_error, 1);
        chk(busy == 0, "rejected_busy", busy, 0);
        pulse_start(MW + 1, 4);
        @(posedge clk);
        #1;
        chk(cfg_error == 1 && busy == 0, "cfg_error_wide", cfg_error, 1);
        pulse_start(5, K - 1);
        @(posedge clk);
        #1;
        chk(cfg_error == 1 && busy == 0, "cfg_error_short", cfg_error, 1);
        start(5, 4, -1, 0, 0);
        wait_done(5, 4, 0);

        start(5, 4, 14, 1, 0);
        wait_done(5, 4, 1);
        start(K, K, -1, 1, 1);
        wait_done(K, K, 0);
        start(MW, K, -1, 0, 1);
        wait_done(MW, K, 0);
        repeat (3) begin
            w = K + int'($urandom % 10);
            h = K + int'($urandom % 5);
            start(w, h, -1, 1, 1);
            wait_done(w, h, 0);
        end

        start(5, 4, -1, 0, 0);
        t = 0;
        while (beats < 9 && t < 2000) begin
            @(posedge clk);
            t++;
        end
        chk(beats >= 9, "reach_beat10", beats, 9);
        #2;
        rst_n = 0;
        #1;
        chk(m_axis_valid == 0, "async_rst_valid", m_axis_valid, 0);
        chk(busy == 0, "async_rst_busy", busy, 0);
        chk(s_axis_ready == 0, "async_rst_s_ready", s_axis_ready, 0);
        chk(m_axis_keep == 0, "async_rst_keep", m_axis_keep, 0);
        abort = 1;
        t = 0;
        while (feed_active && t < 100) begin
            @(posedge clk);
            t++;
        end
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1;
        repeat (2) @(posedge clk);
        #1;
        chk(busy == 0 && m_axis_valid == 0, "idle_after_reset", busy, 0);
        start(5, 4, -1, 1, 0);
        wait_done(5, 4, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
